border_hit_detector: RTL and testbench

// Consumer of the background drawer's per-axis border draw requests. Sees the ball's draw request overlap a border pixel,

---
 rtl/billiard_pkg.sv | 31 +++
 rtl/border_axis_fsm.sv | 79 +++++++
 rtl/border_hit_detector.sv | 78 +++++++
 tb/tb_border_hit_detector.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard border collision logic.
// Axis FSM states, side encoding, frame geometry, saturating counter helper.
package billiard_pkg;

   typedef enum logic [1:0] {
      ARMED,
      PULSE,
      COOLDOWN
   } axis_state_t;

   typedef enum logic {
      SIDE_LO,
      SIDE_HI
   } side_t;

   localparam int FRAME_W = 640;
   localparam int FRAME_H = 480;
   localparam int PIX_W   = 11;
   localparam int CNT_W   = 8;

   // Saturating add of 0..2 pulses to the 8-bit hit counter.
   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] a,
      input logic [1:0]       b
   );
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/border_axis_fsm.sv
// One collision axis: per-frame overlap accumulator, pulse FSM, cooldown.
// Ports: clk, resetN, sof, overlap, sideIn -> hit (1-clk pulse), side (held).
module border_axis_fsm
   import billiard_pkg::*;
#(
   parameter int COOLDOWN_FRAMES = 3
) (
   input  logic clk,
   input  logic resetN,
   input  logic sof,
   input  logic overlap,
   input  logic sideIn,
   output logic hit,
   output logic side
);

   localparam logic [3:0] CD = 4'(COOLDOWN_FRAMES);

   logic        seen;
   side_t       side_rec;
   axis_state_t state;
   logic [3:0]  cnt;

   // Only the first overlap of a frame fixes the side; an overlap
   // coincident with sof starts the new frame's record.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         seen     <= 1'b0;
         side_rec <= SIDE_LO;
      end else if (sof) begin
         seen <= overlap;
         if (overlap)
            side_rec <= side_t'(sideIn);
      end else if (overlap && !seen) begin
         seen     <= 1'b1;
         side_rec <= side_t'(sideIn);
      end
   end

   // Side is latched on the same edge that raises hit, before the
   // accumulator can reload with the next frame's record.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= ARMED;
         cnt   <= 4'd0;
         hit   <= 1'b0;
         side  <= 1'b0;
      end else begin
         hit <= 1'b0;
         unique case (state)
            ARMED: begin
               if (sof && seen) begin
                  state <= PULSE;
                  hit   <= 1'b1;
                  side  <= side_rec;
               end
            end
            PULSE: begin
               cnt   <= CD;
               state <= COOLDOWN;
            end
            COOLDOWN: begin
               if (sof) begin
                  if (seen) begin
                     cnt <= CD;
                  end else if (cnt <= 4'd1) begin
                     cnt   <= 4'd0;
                     state <= ARMED;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
            end
            default: state <= ARMED;
         endcase
      end
   end

endmodule

// File: rtl/border_hit_detector.sv
// Turns ball/border draw-request overlaps into per-frame hit pulses.
// Ports: clk, resetN, startOfFrame, pixelX/Y, ballDR, bordersDrawReq -> hitX/Y, sides, hitCount.
module border_hit_detector
   import billiard_pkg::*;
#(
   parameter int X_MID           = FRAME_W / 2,
   parameter int Y_MID           = FRAME_H / 2,
   parameter int COOLDOWN_FRAMES = 3
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             startOfFrame,
   input  logic [PIX_W-1:0] pixelX,
   input  logic [PIX_W-1:0] pixelY,
   input  logic             ballDR,
   input  logic [1:0]       bordersDrawReq,
   output logic             hitX,
   output logic             hitY,
   output logic             hitXSide,
   output logic             hitYSide,
   output logic [CNT_W-1:0] hitCount
);

   logic [PIX_W-1:0] px_d;
   logic [PIX_W-1:0] py_d;
   logic             overlap_x;
   logic             overlap_y;
   logic             side_x;
   logic             side_y;

   // Draw requests arrive one clock late; delay the pixel position to match.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         px_d <= '0;
         py_d <= '0;
      end else begin
         px_d <= pixelX;
         py_d <= pixelY;
      end
   end

   assign overlap_x = ballDR & bordersDrawReq[0];
   assign overlap_y = ballDR & bordersDrawReq[1];
   assign side_x    = (px_d >= PIX_W'(X_MID));
   assign side_y    = (py_d >= PIX_W'(Y_MID));

   border_axis_fsm #(
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
   ) u_axis_x (
      .clk    (clk),
      .resetN (resetN),
      .sof    (startOfFrame),
      .overlap(overlap_x),
      .sideIn (side_x),
      .hit    (hitX),
      .side   (hitXSide)
   );

   border_axis_fsm #(
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
   ) u_axis_y (
      .clk    (clk),
      .resetN (resetN),
      .sof    (startOfFrame),
      .overlap(overlap_y),
      .sideIn (side_y),
      .hit    (hitY),
      .side   (hitYSide)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         hitCount <= '0;
      else
         hitCount <= sat_add(hitCount, {1'b0, hitX} + {1'b0, hitY});
   end

endmodule

// File: tb/tb_border_hit_detector.sv
// Self-checking bench for border_hit_detector: vector table, directed
// sequences and randomized frames against a frame-level reference model.
module tb_border_hit_detector;

   localparam int C = 3;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic        ballDR = 1'b0;
   logic [1:0]  bordersDrawReq = '0;
   logic        hitX, hitY, hitXSide, hitYSide;
   logic [7:0]  hitCount;

   int errors = 0;
   int checks = 0;
   int n_x = 0;
   int n_y = 0;

   border_hit_detector #(
      .X_MID(320), .Y_MID(240), .COOLDOWN_FRAMES(C)
   ) dut (
      .clk           (clk),
      .resetN        (resetN),
      .startOfFrame  (startOfFrame),
      .pixelX        (pixelX),
      .pixelY        (pixelY),
      .ballDR        (ballDR),
      .bordersDrawReq(bordersDrawReq),
      .hitX          (hitX),
      .hitY          (hitY),
      .hitXSide      (hitXSide),
      .hitYSide      (hitYSide),
      .hitCount      (hitCount)
   );

   always #5 clk = ~clk;

   // Reference model: frame records, cooldown as "clean frames since hit".
   bit          m_seen[2];
   bit          m_side[2];
   bit          m_cool[2];
   int          m_clean[2];
   bit          m_hit[2];
   bit          m_hside[2];
   int          m_cnt;
   int          m_pend;
   logic [10:0] m_px, m_py;

   task automatic model_reset();
      for (int a = 0; a < 2; a++) begin
         m_seen[a] = 0; m_side[a] = 0; m_cool[a] = 0;
         m_clean[a] = 0; m_hit[a] = 0; m_hside[a] = 0;
      end
      m_cnt = 0; m_pend = 0; m_px = '0; m_py = '0;
   endtask

   task automatic model_edge(input bit sof, input bit ball,
                             input logic [1:0] bord,
                             input logic [10:0] px, input logic [10:0] py);
      bit ov[2];
      bit sd[2];
      ov[0] = ball & bord[0];
      ov[1] = ball & bord[1];
      sd[0] = (m_px >= 320);
      sd[1] = (m_py >= 240);
      m_cnt = m_cnt + m_pend;
      if (m_cnt > 255) m_cnt = 255;
      for (int a = 0; a < 2; a++) begin
         m_hit[a] = 0;
         if (sof) begin
            if (m_seen[a]) begin
               if (!m_cool[a]) begin
                  m_hit[a] = 1;
                  m_hside[a] = m_side[a];
                  m_cool[a] = 1;
               end
               m_clean[a] = 0;
            end else if (m_cool[a]) begin
               m_clean[a]++;
               if (m_clean[a] >= C) m_cool[a] = 0;
            end
            m_seen[a] = ov[a];
            if (ov[a]) m_side[a] = sd[a];
         end else if (ov[a] && !m_seen[a]) begin
            m_seen[a] = 1;
            m_side[a] = sd[a];
         end
      end
      m_pend = int'(m_hit[0]) + int'(m_hit[1]);
      m_px = px;
      m_py = py;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("hitX", hitX, m_hit[0]);
      chk("hitY", hitY, m_hit[1]);
      chk("hitXSide", hitXSide, m_hside[0]);
      chk("hitYSide", hitYSide, m_hside[1]);
      chk("hitCount", hitCount, m_cnt);
   endtask

   task automatic step(input bit sof, input bit ball, input logic [1:0] bord,
                       input logic [10:0] px, input logic [10:0] py);
      startOfFrame = sof;
      ballDR = ball;
      bordersDrawReq = bord;
      pixelX = px;
      pixelY = py;
      @(posedge clk);
      model_edge(sof, ball, bord, px, py);
      #1;
      if (hitX) n_x++;
      if (hitY) n_y++;
      chk_model();
   endtask

   // Reset asserted mid-cycle with draw requests active.
   task automatic do_reset();
      #2;
      resetN = 1'b0;
      startOfFrame = 1'b0;
      ballDR = 1'b1;
      bordersDrawReq = 2'b11;
      #1;
      chk("rst_hitX", hitX, 0);
      chk("rst_hitY", hitY, 0);
      chk("rst_sides", {hitXSide, hitYSide}, 0);
      chk("rst_cnt", hitCount, 0);
      model_reset();
      @(posedge clk);
      #1;
      ballDR = 1'b0;
      bordersDrawReq = 2'b00;
      resetN = 1'b1;
   endtask

   task automatic frame(input int len, input bit ox, input bit oy,
                        input logic [10:0] x, input logic [10:0] y);
      int k;
      step(1, 0, 2'b00, 0, 0);
      k = 1;
      if (ox || oy) begin
         step(0, 0, 2'b00, x, y);
         step(0, 1, {oy, ox}, 0, 0);
         k = 3;
      end
      for (int i = k; i < len; i++) step(0, 0, 2'b00, 0, 0);
   endtask

   typedef struct {
      bit          rst;
      bit          sof;
      bit          ball;
      logic [1:0]  bord;
      logic [10:0] px;
      logic [10:0] py;
      bit          hx, hy, sx, sy;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl[15];

   task automatic set_row(input int i, input bit rst, input bit sof,
                          input bit ball, input logic [1:0] bord,
                          input logic [10:0] px, input logic [10:0] py,
                          input bit hx, input bit hy, input bit sx,
                          input bit sy, input logic [7:0] cnt);
      tbl[i] = '{rst, sof, ball, bord, px, py, hx, hy, sx, sy, cnt};
   endtask

   initial begin
      model_reset();
      // Left X hit, then reset, then corner hit on both axes.
      set_row(0,  1, 0, 0, 2'b00, 0,   0,   0, 0, 0, 0, 0);
      set_row(1,  0, 1, 0, 2'b00, 0,   0,   0, 0, 0, 0, 0);
      set_row(2,  0, 0, 0, 2'b00, 10,  100, 0, 0, 0, 0, 0);
      set_row(3,  0, 0, 1, 2'b01, 0,   0,   0, 0, 0, 0, 0);
      set_row(4,  0, 0, 0, 2'b00, 0,   0,   0, 0, 0, 0, 0);
      set_row(5,  0, 1, 0, 2'b00, 0,   0,   1, 0, 0, 0, 0);
      set_row(6,  0, 0, 0, 2'b00, 0,   0,   0, 0, 0, 0, 1);
      set_row(7,  1, 0, 0, 2'b00, 0,   0,   0, 0, 0, 0, 0);
      set_row(8,  0, 0, 0, 2'b00, 0,   0,   0, 0, 0, 0, 0);
      set_row(9,  0, 1, 0, 2'b00, 0,   0,   0, 0, 0, 0, 0);
      set_row(10, 0, 0, 0, 2'b00, 630, 470, 0, 0, 0, 0, 0);
      set_row(11, 0, 0, 1, 2'b11, 0,   0,   0, 0, 0, 0, 0);
      set_row(12, 0, 1, 0, 2'b00, 0,   0,   1, 1, 1, 1, 0);
      set_row(13, 0, 0, 0, 2'b00, 0,   0,   0, 0, 1, 1, 2);
      set_row(14, 0, 1, 0, 2'b00, 0,   0,   0, 0, 1, 1, 2);

      for (int i = 0; i < 15; i++) begin
         if (tbl[i].rst) do_reset();
         else step(tbl[i].sof, tbl[i].ball, tbl[i].bord,
                   tbl[i].px, tbl[i].py);
         chk($sformatf("tbl%0d_hitX", i), hitX, tbl[i].hx);
         chk($sformatf("tbl%0d_hitY", i), hitY, tbl[i].hy);
         chk($sformatf("tbl%0d_sideX", i), hitXSide, tbl[i].sx);
         chk($sformatf("tbl%0d_sideY", i), hitYSide, tbl[i].sy);
         chk($sformatf("tbl%0d_cnt", i), hitCount, tbl[i].cnt);
      end

      // Cooldown: hits in N and N+1, three clean, hit in N+5.
      do_reset();
      n_x = 0;
      frame(4, 1, 0, 10, 0);
      frame(4, 1, 0, 10, 0);
      frame(4, 0, 0, 0, 0);
      frame(4, 0, 0, 0, 0);
      frame(4, 0, 0, 0, 0);
      frame(4, 1, 0, 600, 0);
      frame(4, 0, 0, 0, 0);
      chk("cool_pulses", n_x, 2);
      chk("cool_cnt", hitCount, 2);
      chk("cool_side", hitXSide, 1);

      // Only two clean frames: the hit in the third must be suppressed.
      do_reset();
      n_x = 0;
      frame(4, 1, 0, 10, 0);
      frame(4, 0, 0, 0, 0);
      frame(4, 0, 0, 0, 0);
      frame(4, 1, 0, 10, 0);
      frame(4, 0, 0, 0, 0);
      chk("cool_short_pulses", n_x, 1);

      // Overlap coincident with SOF belongs to the new frame.
      do_reset();
      frame(4, 0, 0, 0, 0);
      step(0, 0, 2'b00, 0, 300);
      step(1, 1, 2'b10, 0, 0);
      chk("sof_ov_nopulse", hitY, 0);
      step(0, 0, 2'b00, 0, 0);
      step(0, 0, 2'b00, 0, 0);
      step(1, 0, 2'b00, 0, 0);
      chk("sof_ov_pulse", hitY, 1);
      chk("sof_ov_side", hitYSide, 1);

      // Missing SOF: long frame keeps the record, pulse at the late SOF.
      do_reset();
      n_x = 0;
      frame(40, 1, 0, 5, 0);
      chk("long_frame_nopulse", n_x, 0);
      frame(3, 0, 0, 0, 0);
      chk("long_frame_pulse", n_x, 1);

      // Randomized frames.
      do_reset();
      for (int f = 0; f < 80; f++) begin
         int len;
         len = $urandom_range(2, 9);
         for (int c = 0; c < len; c++)
            step(c == 0, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)),
                 11'($urandom_range(0, 639)),
                 11'($urandom_range(0, 479)));
      end

      // Saturation: 150 rounds x 2 axes = 300 pulses.
      do_reset();
      for (int r = 0; r < 150; r++) begin
         frame(3, 1, 1, 600, 400);
         frame(3, 0, 0, 0, 0);
         frame(3, 0, 0, 0, 0);
         frame(3, 0, 0, 0, 0);
      end
      frame(3, 0, 0, 0, 0);
      chk("sat_255", hitCount, 255);
      frame(3, 1, 1, 10, 10);
      frame(3, 0, 0, 0, 0);
      frame(3, 0, 0, 0, 0);
      chk("sat_hold", hitCount, 255);
      step(0, 1, 2'b11, 0, 0);
      do_reset();
      chk("post_rst_cnt", hitCount, 0);
      n_x = 0;
      n_y = 0;
      frame(3, 1, 1, 10, 10);
      frame(3, 0, 0, 0, 0);
      chk("post_rst_armed", n_x + n_y, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
